// File: rtl/alu_sweep_seq.sv
// Sweeps every ALU control code over (op_a, op_b) and then (op_b, op_a), emitting one
// valid/ready record per code. Optional reference checker: define ALU_SWEEP_CHECK_EN.
module alu_sweep_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_f,
    input  logic [WIDTH-1:0] alu_y,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [2:0]       res_f,
    output logic             res_swap,
    output logic [WIDTH-1:0] res_y,
    output logic             busy,
    output logic             done
`ifdef ALU_SWEEP_CHECK_EN
    ,
    output logic             err,
    output logic [3:0]       err_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_OUT   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       f_q, f_d;
    logic             swap_q, swap_d;
    logic [2:0]       res_f_q, res_f_d;
    logic             res_swap_q, res_swap_d;
    logic [WIDTH-1:0] res_y_q, res_y_d;

`ifdef ALU_SWEEP_CHECK_EN
    logic             err_q, err_d;
    logic [3:0]       err_cnt_q, err_cnt_d;
    logic [WIDTH-1:0] ref_y;

    always_comb begin
        ref_y = '0;
        case (alu_f)
            3'b000:  ref_y = alu_a & alu_b;
            3'b001:  ref_y = alu_a | alu_b;
            3'b010:  ref_y = alu_a + alu_b;
            3'b100:  ref_y = alu_a & ~alu_b;
            3'b101:  ref_y = alu_a | ~alu_b;
            3'b110:  ref_y = alu_a - alu_b;
            3'b111:  ref_y = {{(WIDTH-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
            default: ref_y = '0;
        endcase
    end
`endif

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        f_d        = f_q;
        swap_d     = swap_q;
        res_f_d    = res_f_q;
        res_swap_d = res_swap_q;
        res_y_d    = res_y_q;
`ifdef ALU_SWEEP_CHECK_EN
        err_d      = err_q;
        err_cnt_d  = err_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    f_d     = 3'b000;
                    swap_d  = 1'b0;
                    state_d = S_DRIVE;
`ifdef ALU_SWEEP_CHECK_EN
                    err_d     = 1'b0;
                    err_cnt_d = 4'd0;
`endif
                end
            end
            S_DRIVE: begin
                res_y_d    = alu_y;
                res_f_d    = f_q;
                res_swap_d = swap_q;
                state_d    = S_OUT;
`ifdef ALU_SWEEP_CHECK_EN
                if (alu_y != ref_y) begin
                    err_d = 1'b1;
                    if (err_cnt_q != 4'd15) err_cnt_d = err_cnt_q + 4'd1;
                end
`endif
            end
            S_OUT: begin
                if (res_ready) begin
                    if (f_q != 3'b111) begin
                        // Code 011 is unused, so ADD steps straight to AND-NOT.
                        f_d     = (f_q == 3'b010) ? 3'b100 : f_q + 3'd1;
                        state_d = S_DRIVE;
                    end else if (!swap_q) begin
                        swap_d  = 1'b1;
                        f_d     = 3'b000;
                        state_d = S_DRIVE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            f_q        <= 3'b000;
            swap_q     <= 1'b0;
            res_f_q    <= 3'b000;
            res_swap_q <= 1'b0;
            res_y_q    <= '0;
`ifdef ALU_SWEEP_CHECK_EN
            err_q      <= 1'b0;
            err_cnt_q  <= 4'd0;
`endif
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            f_q        <= f_d;
            swap_q     <= swap_d;
            res_f_q    <= res_f_d;
            res_swap_q <= res_swap_d;
            res_y_q    <= res_y_d;
`ifdef ALU_SWEEP_CHECK_EN
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
`endif
        end
    end

    assign alu_a     = swap_q ? b_q : a_q;
    assign alu_b     = swap_q ? a_q : b_q;
    assign alu_f     = f_q;
    assign res_valid = (state_q == S_OUT);
    assign res_f     = res_f_q;
    assign res_swap  = res_swap_q;
    assign res_y     = res_y_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
`ifdef ALU_SWEEP_CHECK_EN
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_alu_sweep_seq.sv
// Directed bench for alu_sweep_seq: table of expected records for op_a=25/op_b=7,
// replayed under stall, busy-start, mid-sweep reset and (with the macro) ALU-error sweeps.
module tb_alu_sweep_seq;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] op_a, op_b;
    logic [WIDTH-1:0] alu_a, alu_b, alu_y;
    logic [2:0]       alu_f;
    logic             res_valid, res_ready;
    logic [2:0]       res_f;
    logic             res_swap;
    logic [WIDTH-1:0] res_y;
    logic             busy, done;
`ifdef ALU_SWEEP_CHECK_EN
    logic             err;
    logic [3:0]       err_cnt;
`endif

    int  vectors     = 0;
    int  miscompares = 0;
    bit  saw_f011    = 1'b0;
    bit  corrupt_add = 1'b0;

    always #5 clk = ~clk;

    alu_sweep_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op_a      (op_a),
        .op_b      (op_b),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_f     (alu_f),
        .alu_y     (alu_y),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_f     (res_f),
        .res_swap  (res_swap),
        .res_y     (res_y),
        .busy      (busy),
        .done      (done)
`ifdef ALU_SWEEP_CHECK_EN
        ,
        .err       (err),
        .err_cnt   (err_cnt)
`endif
    );

    // Behavioural ALU feeding the sequencer; corrupt_add injects an off-by-one ADD.
    always_comb begin
        case (alu_f)
            3'b000:  alu_y = alu_a & alu_b;
            3'b001:  alu_y = alu_a | alu_b;
            3'b010:  alu_y = alu_a + alu_b + (corrupt_add ? 32'd1 : 32'd0);
            3'b100:  alu_y = alu_a & ~alu_b;
            3'b101:  alu_y = alu_a | ~alu_b;
            3'b110:  alu_y = alu_a - alu_b;
            3'b111:  alu_y = {31'd0, ($signed(alu_a) < $signed(alu_b))};
            default: alu_y = 32'hDEAD_BEEF;
        endcase
    end

    always @(negedge clk) if (alu_f == 3'b011) saw_f011 = 1'b1;

    typedef struct {
        logic [2:0]  f;
        logic        swap;
        logic [31:0] y;
    } rec_t;

    rec_t tbl[14];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string name);
        check(name, {alu_a, alu_b, alu_f, res_valid, res_f, res_swap, res_y, busy, done}, 128'd0);
`ifdef ALU_SWEEP_CHECK_EN
        check({name, "_err"}, {err, err_cnt}, 128'd0);
`endif
    endtask

    // One full sweep of 25/7. stall_rec: record held 5 cycles with res_ready low;
    // reset_rec: reset asserted during that record's OUT cycle; poke: start with new
    // operands while busy; corrupt: ALU returns ADD+1.
    task automatic run_sweep(input int stall_rec, input int reset_rec, input bit poke,
                             input bit corrupt);
        int cyc;
        int guard;
        int extra;
        logic [31:0] exp_y;
        logic [66:0] alu_hold;
        op_a        = 32'd25;
        op_b        = 32'd7;
        res_ready   = 1'b1;
        corrupt_add = corrupt;
        start       = 1'b1;
        tick;
        start = 1'b0;
        cyc   = 1;
        extra = 0;
        for (int i = 0; i < 14; i++) begin
            guard = 0;
            while (!res_valid && guard < 8) begin
                tick;
                cyc++;
                guard++;
            end
            check("res_valid_seen", {127'd0, res_valid}, 128'd1);
            check("rec_cycle", 128'(cyc), 128'(2 + 2 * i + extra));
            exp_y = tbl[i].y + ((corrupt && tbl[i].f == 3'b010) ? 32'd1 : 32'd0);
            check("record", {res_f, res_swap, res_y}, {tbl[i].f, tbl[i].swap, exp_y});
            $display("rec %0d: f=%b swap=%b y=%h cycle=%0d", i, res_f, res_swap, res_y, cyc);
            if (poke && i == 5) begin
                start = 1'b1;
                op_a  = 32'd1;
                op_b  = 32'd2;
            end
            if (i == stall_rec) begin
                res_ready = 1'b0;
                alu_hold  = {alu_a, alu_b, alu_f};
                for (int s = 0; s < 5; s++) begin
                    tick;
                    cyc++;
                    check("stall_record", {res_valid, res_f, res_swap, res_y},
                          {1'b1, 3'b100, 1'b0, 32'd24});
                    check("stall_alu", {alu_a, alu_b, alu_f}, alu_hold);
                end
                res_ready = 1'b1;
                extra     = 5;
            end
            if (i == reset_rec) begin
                reset = 1'b1;
                tick;
                reset = 1'b0;
                check_reset_vals("reset_mid_sweep");
                corrupt_add = 1'b0;
                return;
            end
            tick;
            cyc++;
            start = 1'b0;
        end
        check("done_state", {done, res_valid, busy}, {1'b1, 1'b0, 1'b1});
        check("done_cycle", 128'(cyc), 128'(29 + extra));
`ifdef ALU_SWEEP_CHECK_EN
        check("err_result", {err, err_cnt}, corrupt ? {1'b1, 4'd2} : {1'b0, 4'd0});
`endif
        start = 1'b1;
        tick;
        start = 1'b0;
        check("after_done", {done, busy, res_valid}, 128'd0);
        tick;
        check("start_in_done_ignored", {done, busy}, 128'd0);
        corrupt_add = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = '{3'b000, 1'b0, 32'd1};
        tbl[1]  = '{3'b001, 1'b0, 32'd31};
        tbl[2]  = '{3'b010, 1'b0, 32'd32};
        tbl[3]  = '{3'b100, 1'b0, 32'd24};
        tbl[4]  = '{3'b101, 1'b0, 32'hFFFF_FFF9};
        tbl[5]  = '{3'b110, 1'b0, 32'd18};
        tbl[6]  = '{3'b111, 1'b0, 32'd0};
        tbl[7]  = '{3'b000, 1'b1, 32'd1};
        tbl[8]  = '{3'b001, 1'b1, 32'd31};
        tbl[9]  = '{3'b010, 1'b1, 32'd32};
        tbl[10] = '{3'b100, 1'b1, 32'd6};
        tbl[11] = '{3'b101, 1'b1, 32'hFFFF_FFE7};
        tbl[12] = '{3'b110, 1'b1, 32'hFFFF_FFEE};
        tbl[13] = '{3'b111, 1'b1, 32'd1};

        reset     = 1'b1;
        start     = 1'b0;
        op_a      = 32'd0;
        op_b      = 32'd0;
        res_ready = 1'b0;
        tick;
        tick;
        check_reset_vals("reset_state");

        // reset wins over a simultaneous start
        op_a  = 32'd25;
        op_b  = 32'd7;
        start = 1'b1;
        tick;
        check("reset_over_start", {busy, res_valid}, 128'd0);
        reset = 1'b0;
        start = 1'b0;
        tick;
        check("idle_no_start", {busy, done}, 128'd0);

        run_sweep(-1, -1, 1'b0, 1'b0);
        run_sweep(3, -1, 1'b0, 1'b0);
        run_sweep(-1, -1, 1'b1, 1'b0);
        run_sweep(-1, 9, 1'b0, 1'b0);
        run_sweep(-1, -1, 1'b0, 1'b0);
`ifdef ALU_SWEEP_CHECK_EN
        run_sweep(-1, -1, 1'b0, 1'b1);
        run_sweep(-1, -1, 1'b0, 1'b0);
`endif

        check("alu_f_never_011", {127'd0, saw_f011}, 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_sweep_seq.md
ALU_SWEEP_SEQ -- requirements
Module: alu_sweep_seq

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a sweep; sampled only in IDLE.
REQ-005 op_a  input  WIDTH  first operand, captured when start is accepted.
REQ-006 op_b  input  WIDTH  second operand, captured when start is accepted.
REQ-007 alu_a  output  WIDTH  operand A driven to the ALU.
REQ-008 alu_b  output  WIDTH  operand B driven to the ALU.
REQ-009 alu_f  output  3  ALU control code driven to the ALU.
REQ-010 alu_y  input  WIDTH  combinational ALU result.
REQ-011 res_valid  output  1  result record available.
REQ-012 res_ready  input  1  consumer accepts the record.
REQ-013 res_f, res_swap, res_y  output  3/1/WIDTH  control code, operand-swap flag and captured result of the record.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse at sweep end.

Function
REQ-016 Control codes: 000 AND, 001 OR, 010 ADD, 011 NOT_USED, 100 AND-NOT, 101 OR-NOT, 110 SUB, 111 SLT.
REQ-017 Sweep order: pass 0 drives (op_a, op_b), pass 1 drives (op_b, op_a); each pass steps f = 000,001,010,100,101,110,111; 011 is never driven; 14 records total.
REQ-018 States: IDLE, DRIVE, OUT, DONE.
REQ-019 IDLE: start=1 -> latch op_a/op_b, f=000, swap=0, go DRIVE; start=0 -> stay.
REQ-020 DRIVE: alu_a/alu_b/alu_f stable for exactly one cycle; at its end alu_y, f, swap latch into res_y/res_f/res_swap; go OUT.
REQ-021 OUT: res_valid=1; record and ALU outputs held unchanged while res_ready=0.
REQ-022 OUT with res_ready=1: f<7 -> next code (010 jumps to 100), go DRIVE; f=7 and swap=0 -> swap=1, f=000, go DRIVE; f=7 and swap=1 -> go DONE.
REQ-023 DONE: done=1 for one cycle, res_valid=0, go IDLE; start in DONE is ignored.
REQ-024 Latency: start high in cycle N -> res_valid high in cycle N+2; with res_ready held high, one record per 2 cycles; done in cycle N+29.
REQ-025 start while busy is ignored; op_a/op_b changes after acceptance have no effect.
REQ-026 Arithmetic on alu_y is not performed; res_y is the raw WIDTH-bit ALU value.

Reset
REQ-027 reset=1 at a rising edge forces IDLE from any state, including mid-sweep with a record pending; the pending record is discarded.
REQ-028 Reset values: alu_a=0, alu_b=0, alu_f=000, res_valid=0, res_f=000, res_swap=0, res_y=0, busy=0, done=0, err=0, err_cnt=0.
REQ-029 reset has priority over start in the same cycle.

Configuration
REQ-030 Macro ALU_SWEEP_CHECK_EN defined: internal reference model computes the expected result per REQ-016 from the driven operands; mismatch at the DRIVE capture edge sets sticky output err (1 bit) and increments output err_cnt (4 bits, saturating at 15); both clear on reset or on start acceptance.
REQ-031 Macro undefined: no reference model, ports err and err_cnt absent; all other behaviour identical.

Verification
REQ-032 op_a=25, op_b=7, res_ready=1 -> pass 0 records (f:y) 000:1, 001:31, 010:32, 100:24, 101:0xFFFFFFF9, 110:18, 111:0.
REQ-033 Same run, pass 1 (res_swap=1) -> 000:1, 001:31, 010:32, 100:6, 101:0xFFFFFFE7, 110:0xFFFFFFEE, 111:1; done at start+29 cycles; alu_f never 011.
REQ-034 res_ready low 5 cycles during record 3 -> res_valid, res_f=100, res_y=24 and alu_* held constant; sweep resumes on first res_ready=1.
REQ-035 reset asserted in OUT of record 9 -> next cycle busy=0, res_valid=0, all outputs at reset values; new start runs a full 14-record sweep.
REQ-036 start pulsed while busy with op_a=1, op_b=2 -> ignored; results still match REQ-032/033.
REQ-037 With ALU_SWEEP_CHECK_EN and an ALU model forcing wrong ADD results -> err=1 and err_cnt=2 after the sweep; correct ALU -> err=0, err_cnt=0.
